// File: rtl/l1_ahb_mtx_dec_param.sv
// Parametrised output-port decoder for one input stage of the L1 AHB matrix.
// Region decode, one-hot selects, data-phase response mux, ERROR default slave, error capture.
module l1_ahb_mtx_dec_param #(
  parameter int unsigned                 NUM_PORTS    = 3,
  parameter int unsigned                 DATA_W       = 32,
  parameter logic [22*NUM_PORTS-1:0]     REGION_BASE  = {22'h0c0000, 22'h080000, 22'h040000},
  parameter logic [22*NUM_PORTS-1:0]     REGION_LIMIT = {22'h0fffff, 22'h08003f, 22'h04003f},
  parameter int unsigned                 ERR_CNT_W    = 8
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic                          HREADYS,
  input  logic                          sel_dec,
  input  logic [21:0]                   decode_addr_dec,
  input  logic [1:0]                    trans_dec,
  input  logic [NUM_PORTS-1:0]          region_en,
  input  logic [NUM_PORTS-1:0]          active_dec_i,
  input  logic [NUM_PORTS-1:0]          readyout_dec_i,
  input  logic [2*NUM_PORTS-1:0]        resp_dec_i,
  input  logic [DATA_W*NUM_PORTS-1:0]   rdata_dec_i,
  input  logic [DATA_W*NUM_PORTS-1:0]   ruser_dec_i,
  input  logic                          err_clr,
  output logic [NUM_PORTS-1:0]          sel_dec_o,
  output logic                          active_dec,
  output logic                          HREADYOUTS,
  output logic [1:0]                    HRESPS,
  output logic [DATA_W-1:0]             HRDATAS,
  output logic [DATA_W-1:0]             HRUSERS,
  output logic                          err_valid,
  output logic [21:0]                   err_addr,
  output logic [ERR_CNT_W-1:0]          err_cnt
);

  localparam int unsigned    PW     = $clog2(NUM_PORTS + 1);
  localparam logic [PW-1:0]  DftIdx = PW'(NUM_PORTS);

  typedef enum logic [1:0] {StIdle, StErr1, StErr2} dft_state_e;

  dft_state_e           state_q, state_d;
  logic                 dft_ready_q;
  logic [1:0]           dft_resp_q;
  logic [PW-1:0]        hit_idx, addr_port;
  logic [PW-1:0]        data_port_q, data_port_d;
  logic                 dft_sel, dft_accept;
  logic                 err_valid_q, err_valid_d;
  logic [21:0]          err_addr_q, err_addr_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Descending scan so the lowest-index hit is the one left standing.
  always_comb begin
    hit_idx = DftIdx;
    for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
      if (region_en[i] &&
          decode_addr_dec >= REGION_BASE[22*i +: 22] &&
          decode_addr_dec <= REGION_LIMIT[22*i +: 22]) begin
        hit_idx = PW'(i);
      end
    end
  end

  // IDLE during a real port's data phase keeps that port selected.
  always_comb begin
    if (trans_dec == 2'b00 && data_port_q != DftIdx) begin
      addr_port = data_port_q;
    end else begin
      addr_port = hit_idx;
    end
  end

  always_comb begin
    sel_dec_o  = '0;
    active_dec = 1'b1;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      sel_dec_o[i] = sel_dec && (addr_port == PW'(i));
      if (addr_port == PW'(i)) begin
        active_dec = active_dec_i[i];
      end
    end
  end

  assign dft_sel     = sel_dec && (addr_port == DftIdx);
  assign dft_accept  = dft_sel && HREADYS && trans_dec[1];
  assign data_port_d = HREADYS ? addr_port : data_port_q;

  always_comb begin
    HREADYOUTS = dft_ready_q;
    HRESPS     = dft_resp_q;
    HRDATAS    = '0;
    HRUSERS    = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (data_port_q == PW'(i)) begin
        HREADYOUTS = readyout_dec_i[i];
        HRESPS     = resp_dec_i[2*i +: 2];
        HRDATAS    = rdata_dec_i[DATA_W*i +: DATA_W];
        HRUSERS    = ruser_dec_i[DATA_W*i +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (dft_accept) state_d = StErr1;
      StErr1:  state_d = StErr2;
      StErr2:  state_d = dft_accept ? StErr1 : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Default-slave outputs are registered from the next state.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= StIdle;
      dft_ready_q <= 1'b1;
      dft_resp_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      dft_ready_q <= (state_d != StErr1);
      dft_resp_q  <= (state_d == StIdle) ? 2'b00 : 2'b01;
    end
  end

  // Clear wins over a same-cycle capture.
  always_comb begin
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    err_cnt_d   = err_cnt_q;
    if (err_clr) begin
      err_valid_d = 1'b0;
      err_addr_d  = '0;
      err_cnt_d   = '0;
    end else if (dft_accept) begin
      if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
      if (!err_valid_q) begin
        err_valid_d = 1'b1;
        err_addr_d  = decode_addr_dec;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      data_port_q <= DftIdx;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      data_port_q <= data_port_d;
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign err_valid = err_valid_q;
  assign err_addr  = err_addr_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_l1_ahb_mtx_dec_param.sv
// Self-checking bench for l1_ahb_mtx_dec_param: decode table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_l1_ahb_mtx_dec_param;

  localparam int N  = 3;
  localparam int DW = 32;

  logic            HCLK = 1'b0;
  logic            HRESET = 1'b1;
  logic            HREADYS = 1'b0;
  logic            sel_dec = 1'b0;
  logic [21:0]     decode_addr_dec = '0;
  logic [1:0]      trans_dec = '0;
  logic [N-1:0]    region_en = '1;
  logic [N-1:0]    active_dec_i = '0;
  logic [N-1:0]    readyout_dec_i = '1;
  logic [2*N-1:0]  resp_dec_i = '0;
  logic [DW*N-1:0] rdata_dec_i = '0;
  logic [DW*N-1:0] ruser_dec_i = '0;
  logic            err_clr = 1'b0;
  logic [N-1:0]    sel_dec_o;
  logic            active_dec;
  logic            HREADYOUTS;
  logic [1:0]      HRESPS;
  logic [DW-1:0]   HRDATAS;
  logic [DW-1:0]   HRUSERS;
  logic            err_valid;
  logic [21:0]     err_addr;
  logic [7:0]      err_cnt;

  l1_ahb_mtx_dec_param dut (
    .HCLK            (HCLK),
    .HRESET          (HRESET),
    .HREADYS         (HREADYS),
    .sel_dec         (sel_dec),
    .decode_addr_dec (decode_addr_dec),
    .trans_dec       (trans_dec),
    .region_en       (region_en),
    .active_dec_i    (active_dec_i),
    .readyout_dec_i  (readyout_dec_i),
    .resp_dec_i      (resp_dec_i),
    .rdata_dec_i     (rdata_dec_i),
    .ruser_dec_i     (ruser_dec_i),
    .err_clr         (err_clr),
    .sel_dec_o       (sel_dec_o),
    .active_dec      (active_dec),
    .HREADYOUTS      (HREADYOUTS),
    .HRESPS          (HRESPS),
    .HRDATAS         (HRDATAS),
    .HRUSERS         (HRUSERS),
    .err_valid       (err_valid),
    .err_addr        (err_addr),
    .err_cnt         (err_cnt)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned rbase[N]  = '{32'h040000, 32'h080000, 32'h0c0000};
  int unsigned rlimit[N] = '{32'h04003f, 32'h08003f, 32'h0fffff};

  typedef struct {
    logic       ready;
    logic [1:0] resp;
  } beat_t;

  beat_t       m_beats[$];   // pending default-slave response beats
  int          m_dp;
  logic        m_ev;
  logic [21:0] m_ea;
  int          m_cnt;

  logic [N-1:0]  e_sel;
  logic          e_act;
  logic          e_rdy;
  logic [1:0]    e_resp;
  logic [DW-1:0] e_rdata;
  logic [DW-1:0] e_ruser;

  function automatic int model_decode(input logic [21:0] a, input logic [N-1:0] en);
    for (int i = 0; i < N; i++) begin
      if (en[i] && 32'(a) >= rbase[i] && 32'(a) <= rlimit[i]) return i;
    end
    return N;
  endfunction

  function automatic int model_addr_port();
    if (trans_dec == 2'b00 && m_dp < N) return m_dp;
    return model_decode(decode_addr_dec, region_en);
  endfunction

  task automatic model_reset();
    m_dp = N;
    m_beats.delete();
    m_ev  = 1'b0;
    m_ea  = '0;
    m_cnt = 0;
  endtask

  task automatic compute_exp();
    int ap;
    ap      = model_addr_port();
    e_sel   = sel_dec ? N'(1 << ap) : '0;
    e_act   = (ap == N) ? 1'b1 : active_dec_i[ap];
    if (m_dp < N) begin
      e_rdy   = readyout_dec_i[m_dp];
      e_resp  = resp_dec_i[2*m_dp +: 2];
      e_rdata = rdata_dec_i[DW*m_dp +: DW];
      e_ruser = ruser_dec_i[DW*m_dp +: DW];
    end else begin
      e_rdy   = (m_beats.size() > 0) ? m_beats[0].ready : 1'b1;
      e_resp  = (m_beats.size() > 0) ? m_beats[0].resp  : 2'b00;
      e_rdata = '0;
      e_ruser = '0;
    end
  endtask

  task automatic model_edge();
    int   ap;
    logic acc;
    beat_t b;
    ap  = model_addr_port();
    acc = sel_dec && (ap == N) && HREADYS && trans_dec[1];
    if (m_beats.size() > 0) void'(m_beats.pop_front());
    if (acc) begin
      m_beats.delete();
      b.ready = 1'b0; b.resp = 2'b01; m_beats.push_back(b);
      b.ready = 1'b1; b.resp = 2'b01; m_beats.push_back(b);
    end
    if (err_clr) begin
      m_ev = 1'b0; m_ea = '0; m_cnt = 0;
    end else if (acc) begin
      if (m_cnt < 255) m_cnt++;
      if (!m_ev) begin
        m_ev = 1'b1;
        m_ea = decode_addr_dec;
      end
    end
    if (HREADYS) m_dp = ap;
  endtask

  // One bus cycle: drive, check outputs mid-cycle, clock, advance model. Entered at posedge+1.
  task automatic step(input logic s, input logic [21:0] a, input logic [1:0] t,
                      input logic [N-1:0] en, input logic clr, input logic allow_stall);
    sel_dec         = s;
    decode_addr_dec = a;
    trans_dec       = t;
    region_en       = en;
    err_clr         = clr;
    compute_exp();
    HREADYS = e_rdy && !(allow_stall && ($urandom_range(0, 7) == 0));
    #2;
    check("sel_dec_o",  64'(sel_dec_o),  64'(e_sel));
    check("active_dec", 64'(active_dec), 64'(e_act));
    check("HREADYOUTS", 64'(HREADYOUTS), 64'(e_rdy));
    check("HRESPS",     64'(HRESPS),     64'(e_resp));
    check("HRDATAS",    64'(HRDATAS),    64'(e_rdata));
    check("HRUSERS",    64'(HRUSERS),    64'(e_ruser));
    check("err_valid",  64'(err_valid),  64'(m_ev));
    check("err_addr",   64'(err_addr),   64'(m_ea));
    check("err_cnt",    64'(err_cnt),    64'(m_cnt));
    @(posedge HCLK);
    model_edge();
    #1;
  endtask

  // ---------------- decode table (data_port at reset value) ----------------
  typedef struct {
    logic         sel;
    logic [21:0]  addr;
    logic [1:0]   trans;
    logic [N-1:0] en;
    logic [N-1:0] act;
    logic [N-1:0] exp_sel;
    logic         exp_act;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [21:0] rand_addr();
    unique case ($urandom_range(0, 4))
      0:       return 22'h040000 + 22'($urandom_range(0, 'h4f));
      1:       return 22'h080000 + 22'($urandom_range(0, 'h4f));
      2:       return 22'h0c0000 + 22'($urandom_range(0, 'h3ffff));
      3:       return 22'h0bfff0 + 22'($urandom_range(0, 'h1f));
      default: return 22'($urandom);
    endcase
  endfunction

  initial begin
    vecs[0] = '{1'b1, 22'h040010, 2'd2, 3'b111, 3'b000, 3'b001, 1'b0};
    vecs[1] = '{1'b1, 22'h04003f, 2'd2, 3'b111, 3'b001, 3'b001, 1'b1};
    vecs[2] = '{1'b1, 22'h040040, 2'd2, 3'b111, 3'b000, 3'b000, 1'b1};
    vecs[3] = '{1'b1, 22'h080000, 2'd3, 3'b111, 3'b010, 3'b010, 1'b1};
    vecs[4] = '{1'b1, 22'h0fffff, 2'd2, 3'b111, 3'b000, 3'b100, 1'b0};
    vecs[5] = '{1'b1, 22'h100000, 2'd2, 3'b111, 3'b000, 3'b000, 1'b1};
    vecs[6] = '{1'b0, 22'h040010, 2'd2, 3'b111, 3'b000, 3'b000, 1'b0};
    vecs[7] = '{1'b1, 22'h0c1234, 2'd2, 3'b011, 3'b111, 3'b000, 1'b1};
    vecs[8] = '{1'b1, 22'h03ffff, 2'd2, 3'b111, 3'b000, 3'b000, 1'b1};
    vecs[9] = '{1'b1, 22'h0c0000, 2'd0, 3'b111, 3'b100, 3'b100, 1'b1};

    #2;
    check("rst_HREADYOUTS", 64'(HREADYOUTS), 64'd1);
    check("rst_HRESPS",     64'(HRESPS),     64'd0);
    check("rst_HRDATAS",    64'(HRDATAS),    64'd0);
    check("rst_err_valid",  64'(err_valid),  64'd0);
    check("rst_err_cnt",    64'(err_cnt),    64'd0);
    #10;
    HRESET = 1'b0;

    // HREADYS held low so data_port stays on the default slave.
    foreach (vecs[i]) begin
      sel_dec         = vecs[i].sel;
      decode_addr_dec = vecs[i].addr;
      trans_dec       = vecs[i].trans;
      region_en       = vecs[i].en;
      active_dec_i    = vecs[i].act;
      #1;
      check($sformatf("tbl%0d_sel", i), 64'(sel_dec_o),  64'(vecs[i].exp_sel));
      check($sformatf("tbl%0d_act", i), 64'(active_dec), 64'(vecs[i].exp_act));
    end

    model_reset();
    active_dec_i   = 3'b101;
    readyout_dec_i = 3'b111;
    resp_dec_i     = '0;
    rdata_dec_i    = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001};
    ruser_dec_i    = {32'h0000_0033, 32'h0000_0022, 32'h0000_0011};
    @(posedge HCLK);
    #1;

    // Port 0 transfer.
    step(1'b1, 22'h040010, 2'd2, 3'b111, 1'b0, 1'b0);
    check("p0_sel", 64'(sel_dec_o), 64'h1);
    check("p0_rdata", 64'(HRDATAS), 64'hA5A5_0001);
    readyout_dec_i = 3'b110;
    #1;
    check("p0_ready_track", 64'(HREADYOUTS), 64'd0);
    readyout_dec_i = 3'b111;
    step(1'b0, 22'h040010, 2'd0, 3'b111, 1'b0, 1'b0);

    // Disabled region -> default slave ERROR.
    step(1'b1, 22'h0c1234, 2'd2, 3'b011, 1'b0, 1'b0);
    check("dft_sel_zero", 64'(sel_dec_o), 64'd0);
    check("err1_ready", 64'(HREADYOUTS), 64'd0);
    check("err1_resp", 64'(HRESPS), 64'd1);
    check("cap_valid", 64'(err_valid), 64'd1);
    check("cap_addr", 64'(err_addr), 64'h0c1234);
    check("cap_cnt", 64'(err_cnt), 64'd1);
    step(1'b1, 22'h000000, 2'd0, 3'b011, 1'b0, 1'b0);
    check("err2_ready", 64'(HREADYOUTS), 64'd1);
    check("err2_resp", 64'(HRESPS), 64'd1);
    // Unmapped IDLE: zero-wait OKAY, nothing counted.
    step(1'b1, 22'h000000, 2'd0, 3'b111, 1'b0, 1'b0);
    check("idle_ready", 64'(HREADYOUTS), 64'd1);
    check("idle_resp", 64'(HRESPS), 64'd0);
    check("idle_cnt", 64'(err_cnt), 64'd1);

    // Hold rule: port 2 in data phase, IDLE to unmapped address.
    step(1'b1, 22'h0c0000, 2'd2, 3'b111, 1'b0, 1'b0);
    step(1'b1, 22'h000000, 2'd0, 3'b111, 1'b0, 1'b0);
    check("hold_sel", 64'(sel_dec_o), 64'h4);
    check("hold_cnt", 64'(err_cnt), 64'd1);

    // Saturation: ~260 back-to-back unmapped NONSEQs.
    step(1'b0, 22'h000000, 2'd0, 3'b111, 1'b1, 1'b0);
    for (int k = 0; k < 520; k++) step(1'b1, 22'h300000 + 22'(k), 2'd2, 3'b111, 1'b0, 1'b0);
    check("sat_cnt", 64'(err_cnt), 64'hff);
    check("sat_addr", 64'(err_addr), 64'h300000);
    check("sat_valid", 64'(err_valid), 64'd1);
    step(1'b1, 22'h3fffff, 2'd2, 3'b111, 1'b1, 1'b0);
    check("clr_valid", 64'(err_valid), 64'd0);
    check("clr_cnt", 64'(err_cnt), 64'd0);
    check("clr_addr", 64'(err_addr), 64'd0);

    // Asynchronous reset while in ERR1.
    check("pre_rst_err1", 64'(HREADYOUTS), 64'd0);
    HRESET = 1'b1;
    #1;
    check("arst_ready", 64'(HREADYOUTS), 64'd1);
    check("arst_resp", 64'(HRESPS), 64'd0);
    check("arst_rdata", 64'(HRDATAS), 64'd0);
    check("arst_ruser", 64'(HRUSERS), 64'd0);
    model_reset();
    sel_dec        = 1'b0;
    readyout_dec_i = 3'b000;
    #2;
    HRESET = 1'b0;
    @(posedge HCLK);
    #1;
    check("post_rst_dft", 64'(HREADYOUTS), 64'd1);
    step(1'b0, 22'h000000, 2'd0, 3'b111, 1'b0, 1'b0);

    // Randomized traffic.
    for (int k = 0; k < 2000; k++) begin
      active_dec_i   = N'($urandom);
      readyout_dec_i = N'($urandom) | N'($urandom);
      resp_dec_i     = (2*N)'($urandom);
      rdata_dec_i    = {$urandom, $urandom, $urandom};
      ruser_dec_i    = {$urandom, $urandom, $urandom};
      step($urandom_range(0, 4) != 0, rand_addr(), 2'($urandom),
           ($urandom_range(0, 3) == 0) ? N'($urandom) : 3'b111,
           $urandom_range(0, 19) == 0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l1_ahb_mtx_dec_param.md
Name: l1_ahb_mtx_dec_param

Overview:
- Parametrised output-port decoder for one slave-side input stage of the L1 AHB matrix. Successor to the fixed three-port decoder.
- Decodes HADDR[31:10] against NUM_PORTS parametrised regions, each with a run-time enable, and drives one-hot port selects.
- Muxes data-phase responses back to the input stage and embeds a two-cycle ERROR default slave.
- Captures the first unmapped access address and counts decode errors for debug/status.

Parameters:
- NUM_PORTS, 3, number of output ports (1..8); the default slave is internal index NUM_PORTS.
- DATA_W, 32, width of HRDATA/HRUSER paths.
- REGION_BASE, {22'h0c0000,22'h080000,22'h040000}, flattened 22*NUM_PORTS; region i base in [22*i+:22], compared against addr[31:10].
- REGION_LIMIT, {22'h0fffff,22'h08003f,22'h04003f}, flattened inclusive upper bounds, same packing.
- ERR_CNT_W, 8, width of the decode-error counter.

Ports:
- HCLK  in  1  AHB clock.
- HRESET  in  1  asynchronous active-high reset.
- HREADYS  in  1  input-stage HREADY (transfer done).
- sel_dec  in  1  HSEL from input stage.
- decode_addr_dec  in  22  HADDR[31:10].
- trans_dec  in  2  HTRANS.
- region_en  in  NUM_PORTS  per-region enable; 0 forces misses to the default slave.
- active_dec_i  in  NUM_PORTS  per-output-stage active flags.
- readyout_dec_i  in  NUM_PORTS  per-port HREADYOUT.
- resp_dec_i  in  2*NUM_PORTS  per-port HRESP.
- rdata_dec_i  in  DATA_W*NUM_PORTS  per-port HRDATA.
- ruser_dec_i  in  DATA_W*NUM_PORTS  per-port HRUSER.
- err_clr  in  1  clears err_valid, err_addr and err_cnt.
- sel_dec_o  out  NUM_PORTS  one-hot HSEL to output stages.
- active_dec  out  1  selected active flag.
- HREADYOUTS  out  1  selected HREADYOUT.
- HRESPS  out  2  selected HRESP.
- HRDATAS  out  DATA_W  selected read data.
- HRUSERS  out  DATA_W  selected read user data.
- err_valid  out  1  sticky: an unmapped NONSEQ/SEQ was accepted.
- err_addr  out  22  addr[31:10] of the first unmapped access.
- err_cnt  out  ERR_CNT_W  saturating count of unmapped accesses.

Behaviour:
- Address decode is combinational. Region i hits when region_en[i] and BASE_i <= addr <= LIMIT_i (unsigned). The lowest-index hit wins; overlapping regions are legal.
- Hold rule: if trans_dec==IDLE and data_port==i with i < NUM_PORTS, addr_port = i regardless of address. Otherwise addr_port is the hit index, or NUM_PORTS if there is no hit.
- sel_dec_o[i] = sel_dec & (addr_port==i). The default slave select is sel_dec & (addr_port==NUM_PORTS). When sel_dec=0, all selects are 0.
- active_dec = active_dec_i[addr_port]; it is 1 when the default slave is selected.
- data_port register: reset value NUM_PORTS. Loads addr_port on the HCLK rising edge when HREADYS=1 and holds otherwise.
- Response mux is indexed by data_port:
  - Real port: readyout/resp/rdata/ruser of that port.
  - Default slave: HREADYOUTS = dft_ready, HRESPS = dft_resp, HRDATAS = 0, HRUSERS = 0.
- Default slave FSM, states IDLE, ERR1, ERR2:
  - IDLE: dft_ready=1, dft_resp=2'b00. Goes to ERR1 when dft_sel & HREADYS & trans_dec[1].
  - ERR1: dft_ready=0, dft_resp=2'b01. Always goes to ERR2.
  - ERR2: dft_ready=1, dft_resp=2'b01. Goes to ERR1 if another qualifying access is accepted in the same cycle, else to IDLE.
  - IDLE/BUSY transfers to an unmapped address get a zero-wait OKAY.
- Error capture: on the qualifying default-slave accept (same condition as IDLE->ERR1):
  - err_cnt increments and saturates at all-ones.
  - If err_valid=0: err_addr is loaded and err_valid is set.
  - err_clr=1 takes priority over a same-cycle capture: the register ends cleared, and the count does not include that access.
- Reset (asynchronous, any time including mid-transfer):
  - data_port = NUM_PORTS and FSM = IDLE.
  - Outputs: HREADYOUTS=1, HRESPS=00, HRDATAS=0, HRUSERS=0.
  - err_valid=0, err_addr=0, err_cnt=0.
  - Any in-flight ERROR is abandoned.
- All mux outputs are combinational. Latency from a registered address phase to the data-phase mux is one cycle.

Test Plan:
- Reset, then sel_dec=1, addr=0x040010, NONSEQ -> sel_dec_o=3'b001. After an HREADYS edge, HRDATAS = rdata_dec_i[31:0] = 0xA5A5_0001 and HREADYOUTS tracks readyout_dec_i[0].
- addr=0x0C1234, NONSEQ, region_en=3'b011 -> default slave selected, sel_dec_o=0. Data phase gives HREADYOUTS 0 then 1 with HRESPS=01 both cycles. err_valid=1, err_addr=0x0C1234, err_cnt=1.
- Unmapped IDLE at addr 0x000000 -> HREADYOUTS=1, HRESPS=00, err_cnt unchanged.
- Port 2 in its data phase, then trans=IDLE at addr 0x000000 -> sel_dec_o=3'b100 (hold rule) and no error counted.
- 256 back-to-back unmapped NONSEQs with ERR_CNT_W=8 -> err_cnt saturates at 0xFF. err_addr holds the first address. err_clr together with a new error -> err_valid=0, err_cnt=0.
- Assert HRESET during ERR1 -> HREADYOUTS=1, HRESPS=00 immediately (asynchronous). After release the FSM is IDLE and data_port selects the default slave.
